// File: rtl/loop_limit_sequencer.sv
// Loop limit sequencer: walks (outer,inner) limit pairs through a
// downstream loop-count stage and accumulates the returned counts.
module loop_limit_sequencer #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic       in_abort,
    input  logic       in_ready,
    input  logic [3:0] in_value,
    output logic [1:0] out_outer_limit,
    output logic [1:0] out_inner_limit,
    output logic       out_valid,
    output logic       out_busy,
    output logic       out_done,
    output logic [7:0] out_sum,
    output logic [3:0] out_max,
    output logic [4:0] out_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Lowest limit value ever issued; 1 when zero limits are skipped.
    localparam logic [1:0] FIRST = SKIP_ZERO ? 2'd1 : 2'd0;

    logic [1:0] r_state;
    logic [1:0] r_outer;
    logic [1:0] r_inner;
    logic [7:0] r_sum;
    logic [3:0] r_max;
    logic [4:0] r_count;

    logic       w_hs;
    logic       w_last;
    logic       w_wrap;
    logic [1:0] w_next_outer;
    logic [1:0] w_next_inner;

    assign w_hs   = (r_state == S_ISSUE) && in_ready;
    assign w_last = (r_outer == 2'd3) && (r_inner == 2'd3);
    assign w_wrap = (r_inner == 2'd3);

    // Next pair in outer-major order; inner restarts at FIRST so skipped
    // zero pairs never cost a cycle.
    always_comb begin
        w_next_inner = r_inner + 2'd1;
        w_next_outer = r_outer;
        if (w_wrap) begin
            w_next_inner = FIRST;
            w_next_outer = r_outer + 2'd1;
        end
    end

    // Control FSM: abort wins over completion on the last pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start)
                        r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (in_abort)
                        r_state <= S_IDLE;
                    else if (w_hs && w_last)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pair indices and accumulators; held outside start and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outer <= 2'd0;
            r_inner <= 2'd0;
            r_sum   <= 8'd0;
            r_max   <= 4'd0;
            r_count <= 5'd0;
        end else if ((r_state == S_IDLE) && in_start) begin
            r_outer <= FIRST;
            r_inner <= FIRST;
            r_sum   <= 8'd0;
            r_max   <= 4'd0;
            r_count <= 5'd0;
        end else if (w_hs) begin
            r_sum   <= r_sum + {4'd0, in_value};
            r_count <= r_count + 5'd1;
            if (in_value > r_max)
                r_max <= in_value;
            if (!w_last) begin
                r_outer <= w_next_outer;
                r_inner <= w_next_inner;
            end
        end
    end

    assign out_outer_limit = r_outer;
    assign out_inner_limit = r_inner;
    assign out_valid       = (r_state == S_ISSUE);
    assign out_busy        = (r_state == S_ISSUE);
    assign out_done        = (r_state == S_DONE);
    assign out_sum         = r_sum;
    assign out_max         = r_max;
    assign out_count       = r_count;

endmodule

// File: tb/tb_loop_limit_sequencer.sv
// Bench for loop_limit_sequencer: both SKIP_ZERO variants checked each
// cycle against a pair-list reference model.
module tb_loop_limit_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, st0, st1, abort, ready;
    logic [3:0] value;

    logic [1:0] a_o, a_i, b_o, b_i;
    logic       a_v, a_b, a_d, b_v, b_b, b_d;
    logic [7:0] a_s, b_s;
    logic [3:0] a_m, b_m;
    logic [4:0] a_c, b_c;

    loop_limit_sequencer #(.SKIP_ZERO(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_start(st0), .in_abort(abort),
        .in_ready(ready), .in_value(value),
        .out_outer_limit(a_o), .out_inner_limit(a_i),
        .out_valid(a_v), .out_busy(a_b), .out_done(a_d),
        .out_sum(a_s), .out_max(a_m), .out_count(a_c));

    loop_limit_sequencer #(.SKIP_ZERO(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_start(st1), .in_abort(abort),
        .in_ready(ready), .in_value(value),
        .out_outer_limit(b_o), .out_inner_limit(b_i),
        .out_valid(b_v), .out_busy(b_b), .out_done(b_d),
        .out_sum(b_s), .out_max(b_m), .out_count(b_c));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model state, one slot per instance.
    bit m_act[2];
    bit m_done[2];
    int m_idx[2], m_sum[2], m_max[2], m_cnt[2], m_lo[2], m_li[2];
    int pl_o[2][16], pl_i[2][16], plen[2];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    // Downstream: nested loop counter that breaks the inner loop at (1,1).
    function automatic int loops(input int o, input int n);
        int c = 0;
        for (int i = 0; i < o; i++)
            for (int j = 0; j < n; j++) begin
                if (i == 1 && j == 1) break;
                c++;
            end
        return c;
    endfunction

    task automatic model_step(input int k, input bit rs, input bit st,
                              input bit ab, input bit rdy, input int v);
        bit last;
        last = 0;
        if (rs) begin
            m_act[k] = 0; m_done[k] = 0; m_idx[k] = 0;
            m_sum[k] = 0; m_max[k] = 0; m_cnt[k] = 0;
            m_lo[k] = 0; m_li[k] = 0;
        end else if (m_done[k]) begin
            m_done[k] = 0;
        end else if (!m_act[k]) begin
            if (st) begin
                m_act[k] = 1; m_idx[k] = 0;
                m_sum[k] = 0; m_max[k] = 0; m_cnt[k] = 0;
                m_lo[k] = pl_o[k][0]; m_li[k] = pl_i[k][0];
            end
        end else begin
            if (rdy) begin
                m_sum[k] += v;
                if (v > m_max[k]) m_max[k] = v;
                m_cnt[k]++;
                if (m_idx[k] == plen[k] - 1) last = 1;
                else begin
                    m_idx[k]++;
                    m_lo[k] = pl_o[k][m_idx[k]];
                    m_li[k] = pl_i[k][m_idx[k]];
                end
            end
            if (ab) m_act[k] = 0;
            else if (last) begin
                m_act[k] = 0; m_done[k] = 1;
            end
        end
    endtask

    task automatic cmp(input string p, input int k,
                       input logic v, input logic b, input logic d,
                       input logic [7:0] s, input logic [3:0] mx,
                       input logic [4:0] cn, input logic [1:0] o,
                       input logic [1:0] i);
        check({p, "valid"}, int'(v), int'(m_act[k]));
        check({p, "busy"}, int'(b), int'(m_act[k]));
        check({p, "done"}, int'(d), int'(m_done[k]));
        check({p, "sum"}, int'(s), m_sum[k]);
        check({p, "max"}, int'(mx), m_max[k]);
        check({p, "count"}, int'(cn), m_cnt[k]);
        check({p, "outer"}, int'(o), m_lo[k]);
        check({p, "inner"}, int'(i), m_li[k]);
    endtask

    task automatic step(input bit s0, input bit s1, input bit ab,
                        input bit rdy, input logic [3:0] v, input bit rs);
        st0 = s0; st1 = s1; abort = ab; ready = rdy; value = v; rst = rs;
        @(posedge clk);
        model_step(0, rs, s0, ab, rdy, int'(v));
        model_step(1, rs, s1, ab, rdy, int'(v));
        #1;
        cyc++;
        cmp("A.", 0, a_v, a_b, a_d, a_s, a_m, a_c, a_o, a_i);
        cmp("B.", 1, b_v, b_b, b_d, b_s, b_m, b_c, b_o, b_i);
    endtask

    function automatic bit dut_valid(input int k);
        return (k == 0) ? a_v : b_v;
    endfunction

    function automatic bit dut_done(input int k);
        return (k == 0) ? a_d : b_d;
    endfunction

    int g_lat;
    int g_dones;

    // mode 0: ready held high, mode 1: ready toggles starting high.
    task automatic sweep(input int k, input int mode, input int abort_hs,
                         input bit rst_mid, input bit poke);
        int first, dn, hs, c;
        bit rdy, ab, rs, sp;
        logic [3:0] v;
        first = -1; dn = -1; hs = 0; g_dones = 0;
        step(k == 0, k == 1, 1'b0, 1'b0, 4'($urandom), 1'b0);
        if (dut_valid(k)) first = cyc;
        for (c = 0; c < 120; c++) begin
            rdy = (mode == 0) ? 1'b1 : (c % 2 == 0);
            if (m_act[k] && rdy) v = 4'(loops(m_lo[k], m_li[k]));
            else v = 4'($urandom);
            ab = 0; rs = 0;
            if (m_act[k] && rdy) begin
                hs++;
                if (hs == abort_hs) ab = 1;
            end
            if (rst_mid && m_act[k] && m_lo[k] == 2 && m_li[k] == 1) rs = 1;
            sp = poke && (c == 3 || c == 9);
            step(k == 0 && sp, k == 1 && sp, ab, rdy, v, rs);
            if (dut_done(k)) begin
                dn = cyc;
                g_dones++;
            end
            if (!m_act[k] && !m_done[k]) break;
        end
        if (c == 120) check("sweep_timeout", 0, 1);
        g_lat = (first >= 0 && dn >= 0) ? dn - first : -1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            plen[k] = 0;
            for (int o = 0; o < 4; o++)
                for (int i = 0; i < 4; i++)
                    if (k == 0 || (o != 0 && i != 0)) begin
                        pl_o[k][plen[k]] = o;
                        pl_i[k][plen[k]] = i;
                        plen[k]++;
                    end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1);
        check("rst_count", int'(a_c), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);

        sweep(0, 0, 0, 1'b0, 1'b0);
        check("full_sum", int'(a_s), 30);
        check("full_max", int'(a_m), 7);
        check("full_count", int'(a_c), 16);
        check("full_latency", g_lat, 16);
        check("full_done_pulses", g_dones, 1);

        sweep(0, 1, 0, 1'b0, 1'b0);
        check("bp_sum", int'(a_s), 30);
        check("bp_count", int'(a_c), 16);
        check("bp_latency", g_lat, 31);

        sweep(1, 0, 0, 1'b0, 1'b0);
        check("skip_sum", int'(b_s), 30);
        check("skip_max", int'(b_m), 7);
        check("skip_count", int'(b_c), 9);
        check("skip_latency", g_lat, 9);

        sweep(0, 0, 5, 1'b0, 1'b0);
        check("abort_count", int'(a_c), 5);
        check("abort_no_done", g_dones, 0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom), 1'b0);

        sweep(0, 0, 0, 1'b1, 1'b0);
        check("rstmid_sum", int'(a_s), 0);
        sweep(0, 0, 0, 1'b0, 1'b0);
        check("after_rst_sum", int'(a_s), 30);

        sweep(0, 0, 0, 1'b0, 1'b1);
        check("poke_sum", int'(a_s), 30);
        check("poke_count", int'(a_c), 16);
        sweep(1, 1, 0, 1'b0, 1'b1);
        check("poke_skip_count", int'(b_c), 9);

        for (int n = 0; n < 800; n++)
            step($urandom_range(7) == 0, $urandom_range(7) == 0,
                 $urandom_range(19) == 0, $urandom_range(1) == 1,
                 4'($urandom), $urandom_range(99) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
